cpu_bus_cycle_master: RTL

- Synthesizable 8088 maximum-mode bus initiator.
- Accepts simple transaction requests from an internal core or test sequencer.
- Generates T1–T4 bus cycles on the chipset's CPU-side interface: status code, address, write data and lock. It waits on `processor_ready` and returns read data.
- It is the CPU end of the status/ready protocol that the chipset's bus arbiter and READY logic decode.

---
 rtl/cpu_bus_cycle_master.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_cycle_master.sv
// 8088 maximum-mode bus initiator: turns simple requests into T1..T4 bus cycles
// with status/lock/address/data outputs, ready-driven wait states and a timeout.
module cpu_bus_cycle_master #(
  parameter int MIN_WAIT       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_status,
  input  logic [19:0] req_address,
  input  logic [7:0]  req_wdata,
  input  logic        req_lock,
  output logic        resp_valid,
  output logic [7:0]  resp_rdata,
  output logic        resp_error,
  output logic [2:0]  processor_status,
  output logic        processor_lock_n,
  output logic [19:0] cpu_address,
  output logic [7:0]  cpu_data_bus,
  input  logic        processor_ready,
  input  logic [7:0]  data_bus
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, TW, T4} state_t;

  localparam logic [2:0] ST_INTA  = 3'b000;
  localparam logic [2:0] ST_IOR   = 3'b001;
  localparam logic [2:0] ST_IOW   = 3'b010;
  localparam logic [2:0] ST_HALT  = 3'b011;
  localparam logic [2:0] ST_FETCH = 3'b100;
  localparam logic [2:0] ST_MEMR  = 3'b101;
  localparam logic [2:0] ST_MEMW  = 3'b110;
  localparam logic [2:0] ST_NONE  = 3'b111;

  localparam logic [3:0]  MIN_WAIT_W    = 4'(MIN_WAIT);
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);

  state_t      state, state_d;
  logic [2:0]  code_q, code_d;
  logic        lock_q, lock_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] tout_q, tout_d;
  logic [19:0] addr_d;
  logic [7:0]  wdata_d;
  logic        resp_valid_d;
  logic [7:0]  rdata_d;
  logic        error_d;
  logic [2:0]  status_d;
  logic        lock_n_d;
  logic        accept;
  logic        is_read;
  logic        bus_active_d;

  assign req_ready = (state == IDLE) || (state == T4);
  assign accept    = req_valid && req_ready;
  assign is_read   = (code_q == ST_INTA) || (code_q == ST_IOR) ||
                     (code_q == ST_FETCH) || (code_q == ST_MEMR);

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    state_d      = state;
    code_d       = code_q;
    lock_d       = lock_q;
    wait_d       = wait_q;
    tout_d       = tout_q;
    addr_d       = cpu_address;
    wdata_d      = cpu_data_bus;
    resp_valid_d = 1'b0;
    rdata_d      = resp_rdata;
    error_d      = resp_error;

    case (state)
      IDLE, T4: begin
        state_d = IDLE;
        lock_d  = 1'b0;
        if (accept) begin
          case (req_status)
            ST_NONE: begin
              resp_valid_d = 1'b1;
              rdata_d      = 8'h00;
              error_d      = 1'b0;
            end
            ST_HALT: begin
              state_d = T1;
              code_d  = ST_HALT;
            end
            default: begin
              state_d = T1;
              code_d  = req_status;
              lock_d  = req_lock;
              addr_d  = req_address;
              if (req_status == ST_IOW || req_status == ST_MEMW) wdata_d = req_wdata;
            end
          endcase
        end
      end
      T1: begin
        if (code_q == ST_HALT) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          rdata_d      = 8'h00;
          error_d      = 1'b0;
        end else begin
          state_d = T2;
        end
      end
      T2: begin
        state_d = T3;
        wait_d  = 4'd0;
        tout_d  = 16'd0;
      end
      T3, TW: begin
        // Ready beats a simultaneous timeout once the minimum wait has elapsed.
        if (processor_ready && wait_q >= MIN_WAIT_W) begin
          state_d      = T4;
          resp_valid_d = 1'b1;
          rdata_d      = is_read ? data_bus : 8'h00;
          error_d      = 1'b0;
        end else if (TIMEOUT_LIMIT != 17'd0 && ({1'b0, tout_q} + 17'd1) >= TIMEOUT_LIMIT) begin
          state_d      = T4;
          resp_valid_d = 1'b1;
          rdata_d      = 8'hFF;
          error_d      = 1'b1;
        end else begin
          state_d = TW;
          wait_d  = (wait_q == 4'hF)     ? wait_q : wait_q + 4'd1;
          tout_d  = (tout_q == 16'hFFFF) ? tout_q : tout_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the bus phase.
    bus_active_d = (state_d == T1) || (state_d == T2) || (state_d == T3) || (state_d == TW);
    status_d     = bus_active_d ? code_d : ST_NONE;
    lock_n_d     = !(lock_d && (bus_active_d || state_d == T4));
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state            <= IDLE;
      code_q           <= ST_NONE;
      lock_q           <= 1'b0;
      wait_q           <= 4'd0;
      tout_q           <= 16'd0;
      cpu_address      <= 20'd0;
      cpu_data_bus     <= 8'd0;
      processor_status <= ST_NONE;
      processor_lock_n <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= 8'd0;
      resp_error       <= 1'b0;
    end else begin
      state            <= state_d;
      code_q           <= code_d;
      lock_q           <= lock_d;
      wait_q           <= wait_d;
      tout_q           <= tout_d;
      cpu_address      <= addr_d;
      cpu_data_bus     <= wdata_d;
      processor_status <= status_d;
      processor_lock_n <= lock_n_d;
      resp_valid       <= resp_valid_d;
      resp_rdata       <= rdata_d;
      resp_error       <= error_d;
    end
  end

endmodule
